seq_lock_prm: RTL and testbench

SEQ_LOCK_PRM -- requirements
Module: seq_lock_prm

---
 rtl/seq_lock_prm.sv | 142 ++++++++++++++
 tb/tb_seq_lock_prm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_lock_prm.sv
// Serial code lock with programmable code, failure counting and timed lockout.
// Bits arrive MSB first; a verdict is only given once a full code has been entered.
module seq_lock_prm #(
    parameter int unsigned CODE_LEN = 6,
    parameter logic [CODE_LEN-1:0] CODE_DEFAULT = 6'b101100,
    parameter int unsigned MAX_FAIL = 3,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter int unsigned UNLOCK_CYC = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic b_in,
    input  logic b_valid,
    input  logic prog_en,
    input  logic relock,
    output logic unlock,
    output logic locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int unsigned FW = $clog2(MAX_FAIL + 1);
    localparam int unsigned IW = $clog2(CODE_LEN);
    localparam int unsigned TMAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
    localparam int unsigned TW = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        S_ENTRY,
        S_UNLOCKED,
        S_PROGRAM,
        S_LOCKOUT
    } state_e;

    state_e              state_q;
    logic [CODE_LEN-1:0] code_q;
    logic [CODE_LEN-2:0] shadow_q;
    logic [IW-1:0]       idx_q;
    logic                err_q;
    logic [FW-1:0]       fail_q;
    logic [TW-1:0]       timer_q;
    logic                unlock_q;
    logic                lockout_q;

    logic [IW-1:0]       bit_sel;
    logic                err_d;
    logic [FW-1:0]       fail_d;
    logic [CODE_LEN-1:0] shadow_d;
    logic                last_bit;

    always_comb begin
        bit_sel  = IW'(CODE_LEN - 1) - idx_q;
        err_d    = err_q | (b_in ^ code_q[bit_sel]);
        fail_d   = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
        shadow_d = {shadow_q, b_in};
        last_bit = (idx_q == IW'(CODE_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= S_ENTRY;
            code_q    <= CODE_DEFAULT;
            shadow_q  <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            fail_q    <= '0;
            timer_q   <= '0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_ENTRY: begin
                    if (b_valid) begin
                        if (last_bit) begin
                            idx_q <= '0;
                            err_q <= 1'b0;
                            if (!err_d) begin
                                state_q  <= S_UNLOCKED;
                                fail_q   <= '0;
                                timer_q  <= '0;
                                unlock_q <= 1'b1;
                            end else begin
                                fail_q <= fail_d;
                                if (fail_d == FW'(MAX_FAIL)) begin
                                    state_q   <= S_LOCKOUT;
                                    timer_q   <= '0;
                                    lockout_q <= 1'b1;
                                end
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            err_q <= err_d;
                        end
                    end
                end
                S_UNLOCKED: begin
                    // relock wins over prog_en on the same cycle
                    if (relock) begin
                        state_q  <= S_ENTRY;
                        unlock_q <= 1'b0;
                    end else if (prog_en) begin
                        state_q  <= S_PROGRAM;
                        unlock_q <= 1'b0;
                        idx_q    <= '0;
                    end else if (timer_q == TW'(UNLOCK_CYC - 1)) begin
                        state_q  <= S_ENTRY;
                        unlock_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_PROGRAM: begin
                    if (relock) begin
                        state_q <= S_ENTRY;
                        idx_q   <= '0;
                    end else if (b_valid) begin
                        shadow_q <= shadow_d[CODE_LEN-2:0];
                        if (last_bit) begin
                            code_q  <= shadow_d;
                            idx_q   <= '0;
                            state_q <= S_ENTRY;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (timer_q == TW'(LOCKOUT_CYC - 1)) begin
                        state_q   <= S_ENTRY;
                        lockout_q <= 1'b0;
                        fail_q    <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign unlock     = unlock_q;
    assign locked_out = lockout_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_seq_lock_prm.sv
// Bench for seq_lock_prm: directed scenarios then random episodes,
// every cycle checked against a queue-based behavioural model.
module tb_seq_lock_prm;

    localparam int CL  = 6;
    localparam int DEF = 6'b101100;
    localparam int MF  = 3;
    localparam int LC  = 16;
    localparam int UC  = 8;

    logic clk = 1'b0;
    logic clear = 1'b0;
    logic b_in = 1'b0;
    logic b_valid = 1'b0;
    logic prog_en = 1'b0;
    logic relock = 1'b0;
    logic unlock;
    logic locked_out;
    logic [1:0] fail_cnt;

    int n_chk = 0;
    int n_err = 0;

    // behavioural reference: 0 entry, 1 open, 2 program, 3 lockout
    int mode = 0;
    int left = 0;
    int fails = 0;
    int code = DEF;
    bit bits[$];

    seq_lock_prm dut (
        .clk(clk),
        .clear(clear),
        .b_in(b_in),
        .b_valid(b_valid),
        .prog_en(prog_en),
        .relock(relock),
        .unlock(unlock),
        .locked_out(locked_out),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pack();
        int v = 0;
        foreach (bits[i]) v = (v << 1) | int'(bits[i]);
        return v;
    endfunction

    task automatic model(input bit c, input bit b, input bit bv, input bit pe, input bit rl);
        if (c) begin
            mode = 0; left = 0; fails = 0; code = DEF; bits.delete();
        end else begin
            case (mode)
                0: if (bv) begin
                    bits.push_back(b);
                    if (bits.size() == CL) begin
                        if (pack() == code) begin
                            mode = 1; left = UC; fails = 0;
                        end else begin
                            if (fails < MF) fails++;
                            if (fails == MF) begin
                                mode = 3; left = LC;
                            end
                        end
                        bits.delete();
                    end
                end
                1: if (rl) mode = 0;
                   else if (pe) begin
                       mode = 2; bits.delete();
                   end else begin
                       left--;
                       if (left == 0) mode = 0;
                   end
                2: if (rl) begin
                       mode = 0; bits.delete();
                   end else if (bv) begin
                       bits.push_back(b);
                       if (bits.size() == CL) begin
                           code = pack(); mode = 0; bits.delete();
                       end
                   end
                default: begin
                    left--;
                    if (left == 0) begin
                        mode = 0; fails = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic cyc(input bit c, input bit b, input bit bv, input bit pe, input bit rl);
        @(negedge clk);
        clear = c; b_in = b; b_valid = bv; prog_en = pe; relock = rl;
        @(posedge clk);
        model(c, b, bv, pe, rl);
        #1;
        check("unlock", int'(unlock), int'(mode == 1));
        check("locked_out", int'(locked_out), int'(mode == 3));
        check("fail_cnt", int'(fail_cnt), fails);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input int val, input int nb, input int maxgap);
        for (int i = CL - 1; i >= CL - nb; i--) begin
            idle($urandom_range(maxgap, 0));
            cyc(1'b0, 1'((val >> i) & 1), 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int k;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_unlock", int'(unlock), 0);

        send(6'b101100, CL, 0); idle(10);
        send(6'b110100, CL, 0); idle(1);
        check("one_fail", int'(fail_cnt), 1);
        send(6'b101100, CL, 0); idle(10);

        send(6'b000000, CL, 0);
        send(6'b111111, CL, 0);
        send(6'b101101, CL, 0);
        check("lockout_on", int'(locked_out), 1);
        send(6'b101100, CL, 0); idle(12);
        send(6'b101100, CL, 0); idle(10);

        send(6'b101100, CL, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(6'b001101, CL, 0); idle(2);
        send(6'b101100, CL, 0); idle(1);
        check("old_code_fails", int'(fail_cnt), 1);
        send(6'b001101, CL, 0); idle(10);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(6'b101100, 3, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(6'b101100, CL, 0); idle(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(6'b001101, CL, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(6'b101100, CL, 0); idle(10);

        send(6'b101100, CL, 3); idle(2);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(6'b101100, CL, 1); idle(1);
        check("code_kept", int'(unlock), 1);
        idle(10);

        for (int ep = 0; ep < 80; ep++) begin
            k = $urandom_range(9, 0);
            if (k < 3) send(code, CL, 3);
            else if (k < 5) send($urandom_range(63, 0), CL, 2);
            else if (k == 5) begin
                send(code, CL, 1);
                cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(3, 0) == 0));
                send($urandom_range(63, 0), $urandom_range(CL, 1), 2);
            end else if (k == 6) begin
                cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else if (k == 7) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            else begin
                for (int j = 0; j < 12; j++)
                    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom_range(7, 0) == 0),
                        1'($urandom_range(7, 0) == 0));
            end
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
